// File: rtl/q26_to_bcd_if.sv
// Request/result bundle between the quotient register and the Q2.6-to-BCD converter.
interface q26_to_bcd_if #(
  parameter int unsigned FRAC_DIGITS = 3
) ();
  logic                     start;
  logic [7:0]               din;
  logic                     busy;
  logic                     done;
  logic                     neg;
  logic [3:0]               int_bcd;
  logic [4*FRAC_DIGITS-1:0] frac_bcd;

  modport master (
    output start,
    output din,
    input  busy,
    input  done,
    input  neg,
    input  int_bcd,
    input  frac_bcd
  );

  modport slave (
    input  start,
    input  din,
    output busy,
    output done,
    output neg,
    output int_bcd,
    output frac_bcd
  );
endinterface

// File: rtl/q26_to_bcd.sv
// Serial signed Q2.6 to sign/integer/fractional BCD converter; one fractional digit
// is produced per clock by repeated multiply-by-ten of the 6-bit remainder.
module q26_to_bcd #(
  parameter int unsigned FRAC_DIGITS = 3
) (
  input logic         CLOCK_50,
  input logic         rst,
  q26_to_bcd_if.slave bus
);
  localparam int unsigned FracW = 4 * FRAC_DIGITS;
  localparam int unsigned CntW  = (FRAC_DIGITS > 1) ? $clog2(FRAC_DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAC_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StConv, StFin} state_e;

  state_e            r_state, w_state_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_neg, w_neg_d;
  logic [3:0]        r_int, w_int_d;
  logic [FracW-1:0]  r_frac, w_frac_d;
  logic [5:0]        r_rem, w_rem_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;

  logic [7:0]        w_mag;
  logic [9:0]        w_prod;
  logic [FracW-1:0]  w_frac_shift;

  // 0x80 negates to itself, which read as unsigned is exactly 2.0.
  assign w_mag        = bus.din[7] ? (~bus.din + 8'd1) : bus.din;
  // rem*10 as rem*8 + rem*2; the top nibble is the next decimal digit.
  assign w_prod       = {1'b0, r_rem, 3'b000} + {3'b000, r_rem, 1'b0};
  assign w_frac_shift = (r_frac << 4) | FracW'(w_prod[9:6]);

  always_comb begin
    w_state_d = r_state;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_neg_d   = r_neg;
    w_int_d   = r_int;
    w_frac_d  = r_frac;
    w_rem_d   = r_rem;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_neg_d   = bus.din[7];
          w_int_d   = {2'b00, w_mag[7:6]};
          w_rem_d   = w_mag[5:0];
          w_cnt_d   = '0;
          w_frac_d  = '0;
          w_busy_d  = 1'b1;
          w_state_d = StConv;
        end
      end
      StConv: begin
        w_frac_d = w_frac_shift;
        w_rem_d  = w_prod[5:0];
        w_cnt_d  = r_cnt + 1'b1;
        if (r_cnt == LastCnt) begin
          w_state_d = StFin;
        end
      end
      StFin: begin
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: begin
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_neg   <= 1'b0;
      r_int   <= '0;
      r_frac  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_neg   <= w_neg_d;
      r_int   <= w_int_d;
      r_frac  <= w_frac_d;
      r_rem   <= w_rem_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.neg      = r_neg;
  assign bus.int_bcd  = r_int;
  assign bus.frac_bcd = r_frac;
endmodule

// File: tb/tb_q26_to_bcd.sv
// Scoreboard bench for q26_to_bcd: two instances (3 and 6 fractional digits).
module tb_q26_to_bcd;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q26_to_bcd_if #(.FRAC_DIGITS(3)) if3 ();
  q26_to_bcd_if #(.FRAC_DIGITS(6)) if6 ();

  q26_to_bcd #(.FRAC_DIGITS(3)) u_dut3 (.CLOCK_50(clk), .rst(rst), .bus(if3));
  q26_to_bcd #(.FRAC_DIGITS(6)) u_dut6 (.CLOCK_50(clk), .rst(rst), .bus(if6));

  typedef struct packed {
    logic        neg;
    logic [3:0]  ib;
    logic [23:0] fb;
  } exp_t;

  exp_t q3[$];
  exp_t q6[$];
  int   errors = 0;
  int   checks = 0;
  int   dones3 = 0;
  int   dones6 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic n, input logic [3:0] i, input logic [23:0] f);
    exp_t e;
    e.neg = n;
    e.ib  = i;
    e.fb  = f;
    return e;
  endfunction

  // Decimal reference: |v|/64 = int + (|v|%64)*15625 / 10^6, truncated to f digits.
  function automatic exp_t model(input logic [7:0] d, input int f);
    exp_t e;
    int v, m, fr, p;
    v = $signed(d);
    m = (v < 0) ? -v : v;
    e.neg = (v < 0);
    e.ib  = 4'(m / 64);
    p = 1;
    for (int i = 0; i < 6 - f; i++) p = p * 10;
    fr = ((m % 64) * 15625) / p;
    e.fb = '0;
    for (int i = 0; i < f; i++) begin
      e.fb = e.fb | (24'(fr % 10) << (4 * i));
      fr = fr / 10;
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon3
    exp_t e;
    if (if3.done === 1'b1) begin
      dones3++;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut3 spurious done: got done=1, expected no pending conversion");
      end else begin
        e = q3.pop_front();
        check("dut3 result", {3'b0, if3.neg, if3.int_bcd, 12'b0, if3.frac_bcd},
              {3'b0, e.neg, e.ib, e.fb});
        check("dut3 busy at done", 32'(if3.busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon6
    exp_t e;
    if (if6.done === 1'b1) begin
      dones6++;
      if (q6.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut6 spurious done: got done=1, expected no pending conversion");
      end else begin
        e = q6.pop_front();
        check("dut6 result", {3'b0, if6.neg, if6.int_bcd, if6.frac_bcd},
              {3'b0, e.neg, e.ib, e.fb});
      end
    end
  end

  task automatic wait_idle(input bit sel);
    int n = 0;
    @(negedge clk);
    while (((sel ? if6.busy : if3.busy) !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout: busy still %0b after %0d cycles", 1'b1, n);
    end
  endtask

  // One conversion; optionally pokes a stray start with garbage din mid-conversion.
  task automatic run_conv(input bit sel, input logic [7:0] d, input exp_t e, input bit poke);
    int n;
    int f;
    f = sel ? 6 : 3;
    wait_idle(sel);
    if (sel) begin
      if6.start = 1'b1; if6.din = d; q6.push_back(e);
    end else begin
      if3.start = 1'b1; if3.din = d; q3.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel) begin
      if6.start = 1'b0; if6.din = 8'($urandom);
    end else begin
      if3.start = 1'b0; if3.din = 8'($urandom);
    end
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if ((sel ? if6.done : if3.done) === 1'b1) break;
      if (poke && n == 1) begin
        if (sel) begin if6.start = 1'b1; if6.din = 8'($urandom); end
        else begin if3.start = 1'b1; if3.din = 8'($urandom); end
      end
      if (poke && n == 2) begin
        if (sel) if6.start = 1'b0;
        else if3.start = 1'b0;
      end
      n++;
    end
    check(sel ? "dut6 latency" : "dut3 latency", 32'(n), 32'(f + 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((q3.size() != 0 || q6.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain pending", 32'(q3.size() + q6.size()), 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    if3.start = 1'b0; if3.din = 8'h00;
    if6.start = 1'b0; if6.din = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", {if3.busy, if3.done, if3.neg, if3.int_bcd, if3.frac_bcd}, 32'd0);
    rst = 1'b0;

    // Reset asserted two clocks into a conversion aborts it with no done.
    @(negedge clk);
    if3.start = 1'b1; if3.din = 8'h7F;
    @(posedge clk);
    #1 if3.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort outputs", {if3.busy, if3.done, if3.neg, if3.int_bcd, if3.frac_bcd}, 32'd0);
    rst = 1'b0;
    base = dones3;
    repeat (12) @(negedge clk);
    check("abort no done", 32'(dones3 - base), 32'd0);

    // Directed values with hand-derived decimal expansions.
    run_conv(1'b0, 8'h40, mk(1'b0, 4'd1, 24'h000), 1'b0);
    run_conv(1'b0, 8'hD5, mk(1'b1, 4'd0, 24'h671), 1'b1);
    run_conv(1'b0, 8'h7F, mk(1'b0, 4'd1, 24'h984), 1'b0);
    run_conv(1'b0, 8'h80, mk(1'b1, 4'd2, 24'h000), 1'b1);
    run_conv(1'b0, 8'h01, mk(1'b0, 4'd0, 24'h015), 1'b0);
    run_conv(1'b0, 8'hFF, mk(1'b1, 4'd0, 24'h015), 1'b1);
    run_conv(1'b0, 8'h00, mk(1'b0, 4'd0, 24'h000), 1'b0);
    run_conv(1'b1, 8'h2B, mk(1'b0, 4'd0, 24'h671875), 1'b1);
    run_conv(1'b1, 8'h80, mk(1'b1, 4'd2, 24'h000000), 1'b0);

    // start held high: one conversion every 5 clocks, din only stable at acceptance edges.
    wait_idle(1'b0);
    base = dones3;
    if3.start = 1'b1; if3.din = 8'h40;
    for (int k = 0; k < 4; k++) q3.push_back(mk(1'b0, 4'd1, 24'h000));
    for (int e = 0; e <= 15; e++) begin
      @(posedge clk);
      #1;
      if (e == 15) if3.start = 1'b0;
      else if ((e + 1) % 5 == 0) if3.din = 8'h40;
      else if3.din = 8'($urandom);
    end
    drain();
    repeat (8) @(negedge clk);
    check("held start done count", 32'(dones3 - base), 32'd4);

    // Random values on the 3-digit instance.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      run_conv(1'b0, d, model(d, 3), 1'($urandom_range(0, 1)));
    end

    // Full sweep on the exact 6-digit instance.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'(i);
      run_conv(1'b1, d, model(d, 6), 1'b0);
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
